fetch_stage: RTL

// - Instruction-fetch stage directly upstream of decode. Owns the PC and issues one

---
 rtl/fetch_stage.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, IF/ID register with 1-entry skid.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        id_stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_plus2,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_squashed
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] pc_r, pc_s;
    logic        imem_req_r, imem_req_s;
    logic        halted_r, halted_s;
    logic [15:0] ifid_instr_r, ifid_instr_s;
    logic [15:0] ifid_pc2_r, ifid_pc2_s;
    logic        ifid_valid_r, ifid_valid_s;
    logic        skid_full_r, skid_full_s;
    logic [15:0] skid_instr_r, skid_instr_s;
    logic [15:0] skid_pc2_r, skid_pc2_s;
    logic        accept_s;
    logic        resp_s;
    logic [15:0] pc_plus2_s;

    assign accept_s   = imem_req_r & imem_gnt;
    assign resp_s     = (state_r == S_WAIT) & imem_rvalid;
    assign pc_plus2_s = pc_r + 16'd2;

    assign imem_req       = imem_req_r;
    assign imem_addr      = pc_r;
    assign halted         = halted_r;
    assign if_id_instr    = ifid_instr_r;
    assign if_id_pc_plus2 = ifid_pc2_r;
    assign if_id_valid    = ifid_valid_r;

    // Next-state, PC, IF/ID and skid update; redirect overrides stall and response handling
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        ifid_instr_s = ifid_instr_r;
        ifid_pc2_s   = ifid_pc2_r;
        ifid_valid_s = ifid_valid_r;
        skid_full_s  = skid_full_r;
        skid_instr_s = skid_instr_r;
        skid_pc2_s   = skid_pc2_r;
        if (branch_taken) begin
            pc_s         = branch_target;
            ifid_valid_s = 1'b0;
            ifid_instr_s = NOP_INSTR;
            skid_full_s  = 1'b0;
            case (state_r)
                S_WAIT:  state_s = imem_rvalid ? S_FETCH : S_DRAIN;
                S_FETCH: state_s = accept_s ? S_DRAIN : S_FETCH;
                default: state_s = S_FETCH;
            endcase
        end else begin
            if (!id_stall) begin
                if (skid_full_r) begin
                    ifid_instr_s = skid_instr_r;
                    ifid_pc2_s   = skid_pc2_r;
                    ifid_valid_s = 1'b1;
                    skid_full_s  = 1'b0;
                end else if (resp_s) begin
                    ifid_instr_s = imem_rdata;
                    ifid_pc2_s   = pc_plus2_s;
                    ifid_valid_s = 1'b1;
                end else begin
                    ifid_instr_s = NOP_INSTR;
                    ifid_valid_s = 1'b0;
                end
            end else if (resp_s && !ifid_valid_r) begin
                ifid_instr_s = imem_rdata;
                ifid_pc2_s   = pc_plus2_s;
                ifid_valid_s = 1'b1;
            end else if (resp_s) begin
                // decode holds a live entry: park the response in the skid
                skid_full_s  = 1'b1;
                skid_instr_s = imem_rdata;
                skid_pc2_s   = pc_plus2_s;
            end else begin
                ifid_valid_s = ifid_valid_r;
            end
            case (state_r)
                S_FETCH: state_s = accept_s ? S_WAIT : S_FETCH;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_s    = pc_plus2_s;
                        state_s = (imem_rdata[15:12] == 4'hF) ? S_HALTED : S_FETCH;
                    end else begin
                        state_s = S_WAIT;
                    end
                end
                S_DRAIN:  state_s = imem_rvalid ? S_FETCH : S_DRAIN;
                S_HALTED: state_s = S_HALTED;
                default:  state_s = S_FETCH;
            endcase
        end
        imem_req_s = (state_s == S_FETCH) & !skid_full_s;
        halted_s   = (state_s == S_HALTED);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_FETCH;
            pc_r         <= RESET_PC;
            imem_req_r   <= 1'b0;
            halted_r     <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc2_r   <= 16'h0000;
            ifid_valid_r <= 1'b0;
            skid_full_r  <= 1'b0;
            skid_instr_r <= 16'h0000;
            skid_pc2_r   <= 16'h0000;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            imem_req_r   <= imem_req_s;
            halted_r     <= halted_s;
            ifid_instr_r <= ifid_instr_s;
            ifid_pc2_r   <= ifid_pc2_s;
            ifid_valid_r <= ifid_valid_s;
            skid_full_r  <= skid_full_s;
            skid_instr_r <= skid_instr_s;
            skid_pc2_r   <= skid_pc2_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic        fetch_cnt_s;
    logic        squash_cnt_s;
    logic [15:0] perf_fetched_r;
    logic [15:0] perf_squashed_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    assign fetch_cnt_s  = !branch_taken & resp_s;
    // a WAIT state or a same-cycle accept means a response is in flight and gets dropped
    assign squash_cnt_s = branch_taken & (ifid_valid_r | skid_full_r | (state_r == S_WAIT) | accept_s);
    assign perf_fetched  = perf_fetched_r;
    assign perf_squashed = perf_squashed_r;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r  <= 16'h0000;
            perf_squashed_r <= 16'h0000;
        end else begin
            perf_fetched_r  <= fetch_cnt_s  ? sat_inc(perf_fetched_r)  : perf_fetched_r;
            perf_squashed_r <= squash_cnt_s ? sat_inc(perf_squashed_r) : perf_squashed_r;
        end
    end
`endif

endmodule
